// File: rtl/line_drawer_pkg.sv
// Shared display parameters and line-drawer types, imported by the drawer,
// its caller and the framebuffer.
package line_drawer_pkg;

    localparam int unsigned DispHorActive = 640;
    localparam int unsigned DispVerActive = 480;

    // Coordinate width for a given active resolution.
    function automatic int unsigned coord_width(input int unsigned active);
        return $clog2(active);
    endfunction

    typedef enum logic {
        StIdle = 1'b0,
        StDraw = 1'b1
    } state_e;

endpackage

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: accepts two endpoints, then streams one pixel per
// accepted handshake until the far endpoint has been emitted.
module line_drawer
    import line_drawer_pkg::*;
#(
    parameter int unsigned HOR_ACTIVE_PIXELS = DispHorActive,
    parameter int unsigned VER_ACTIVE_PIXELS = DispVerActive,
    localparam int unsigned X_WIDTH = coord_width(HOR_ACTIVE_PIXELS),
    localparam int unsigned Y_WIDTH = coord_width(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [Y_WIDTH-1:0] y2,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               pixel_valid,
    input  logic               pixel_ready
);

    localparam int unsigned EW = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

    state_e                state_q, state_d;
    logic [X_WIDTH-1:0]    x_q, x_d, xe_q, xe_d;
    logic [Y_WIDTH-1:0]    y_q, y_d, ye_q, ye_d;
    logic signed [EW-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    // Direction flags: 1 means step by -1.
    logic                  sx_q, sx_d, sy_q, sy_d;

    logic [EW-1:0]         adx, ady;
    logic signed [EW:0]    e2, dx_w, dy_w;
    logic                  step_x, step_y, at_end;

    always_comb begin
        adx    = (x1 < x2) ? EW'(x2) - EW'(x1) : EW'(x1) - EW'(x2);
        ady    = (y1 < y2) ? EW'(y2) - EW'(y1) : EW'(y1) - EW'(y2);
        e2     = {err_q, 1'b0};
        dx_w   = {dx_q[EW-1], dx_q};
        dy_w   = {dy_q[EW-1], dy_q};
        step_x = (e2 >= dy_w);
        step_y = (e2 <= dx_w);
        at_end = (x_q == xe_q) && (y_q == ye_q);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDraw;
                    x_d     = x1;
                    y_d     = y1;
                    xe_d    = x2;
                    ye_d    = y2;
                    dx_d    = adx;
                    dy_d    = -ady;
                    err_d   = adx - ady;
                    sx_d    = !(x1 < x2);
                    sy_d    = !(y1 < y2);
                end
            end
            StDraw: begin
                if (pixel_ready) begin
                    if (at_end) begin
                        state_d = StIdle;
                    end else begin
                        // Both updates use the pre-step error term.
                        err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
                        if (step_x) x_d = sx_q ? x_q - 1'b1 : x_q + 1'b1;
                        if (step_y) y_d = sy_q ? y_q - 1'b1 : y_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

    assign ready       = (state_q == StIdle);
    assign pixel_valid = (state_q == StDraw);
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;

endmodule
